// File: rtl/game_io_bridge.sv
// Board-side I/O bridge for the dinosaur game: debounced buttons, per-frame snapshots of
// the processor's sprite registers, collision detection and sticky flags the processor acknowledges.

module game_io_debounce #(
  parameter int CYCLES = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic state
);
  localparam int CW = $clog2(CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(CYCLES - 1);

  logic [CW-1:0] cnt;

  // The input must disagree with the held state for CYCLES consecutive cycles before the
  // state follows it; a single agreeing cycle restarts the count.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= 1'b0;
      cnt   <= '0;
    end else if (din == state) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      state <= ~state;
      cnt   <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end
endmodule

module game_io_bridge #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DINO_X          = 40,
  parameter int DINO_W          = 20,
  parameter int DINO_H          = 24,
  parameter int OBST_W          = 12,
  parameter int OBST_H          = 20,
  parameter int GROUND_Y        = 200
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        btn_raw,
  input  logic        pause_raw,
  input  logic        vsync_raw,
  input  logic [31:0] dino_y_in,
  input  logic [31:0] obst_x_in,
  input  logic [31:0] ack_word,
  output logic        button_signal,
  output logic        screen_signal,
  output logic        collision_signal,
  output logic        pause_signal,
  output logic [31:0] dino_y_disp,
  output logic [31:0] obst_x_disp
);
  localparam logic [32:0] X_RIGHT = 33'(DINO_X + DINO_W);
  localparam logic [32:0] X_LEFT  = 33'(DINO_X);
  localparam logic [32:0] OW      = 33'(OBST_W);
  localparam logic [32:0] DH      = 33'(DINO_H);
  localparam logic [32:0] OBST_TOP = 33'(GROUND_Y - OBST_H);

  logic btn_s1, btn_s2, pause_s1, pause_s2, vs_s1, vs_s2, vs_prev;
  logic btn_deb, btn_deb_q, pause_deb, pause_deb_q;
  logic [2:0] ack_q, ack_d;
  logic check_pending;

  logic btn_rise, pause_rise, vs_rise;
  logic [2:0] ack_rise;
  logic x_hit, y_hit, coll_hit;
  logic unused_ack;

  assign unused_ack = ^ack_word[31:3];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      btn_s1   <= 1'b0;
      btn_s2   <= 1'b0;
      pause_s1 <= 1'b0;
      pause_s2 <= 1'b0;
      vs_s1    <= 1'b0;
      vs_s2    <= 1'b0;
      vs_prev  <= 1'b0;
    end else begin
      btn_s1   <= btn_raw;
      btn_s2   <= btn_s1;
      pause_s1 <= pause_raw;
      pause_s2 <= pause_s1;
      vs_s1    <= vsync_raw;
      vs_s2    <= vs_s1;
      vs_prev  <= vs_s2;
    end
  end

  game_io_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_btn_deb (
    .clock (clock),
    .reset (reset),
    .din   (btn_s2),
    .state (btn_deb)
  );

  game_io_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_pause_deb (
    .clock (clock),
    .reset (reset),
    .din   (pause_s2),
    .state (pause_deb)
  );

  // ack_word is already in this clock domain, so a single register plus a delayed copy
  // is enough to find its rising edges.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ack_q       <= 3'b000;
      ack_d       <= 3'b000;
      btn_deb_q   <= 1'b0;
      pause_deb_q <= 1'b0;
    end else begin
      ack_q       <= ack_word[2:0];
      ack_d       <= ack_q;
      btn_deb_q   <= btn_deb;
      pause_deb_q <= pause_deb;
    end
  end

  assign btn_rise   = btn_deb & ~btn_deb_q;
  assign pause_rise = pause_deb & ~pause_deb_q;
  assign vs_rise    = vs_s2 & ~vs_prev;
  assign ack_rise   = ack_q & ~ack_d;

  // 33-bit compares so that large register values cannot wrap into a false overlap.
  assign x_hit    = ({1'b0, obst_x_disp} < X_RIGHT) && (({1'b0, obst_x_disp} + OW) > X_LEFT);
  assign y_hit    = ({1'b0, dino_y_disp} + DH) > OBST_TOP;
  assign coll_hit = x_hit && y_hit;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dino_y_disp   <= 32'd0;
      obst_x_disp   <= 32'd0;
      check_pending <= 1'b0;
    end else begin
      check_pending <= vs_rise;
      if (vs_rise) begin
        dino_y_disp <= dino_y_in;
        obst_x_disp <= obst_x_in;
      end
    end
  end

  // Setting takes priority over an acknowledge landing on the same edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      button_signal    <= 1'b0;
      screen_signal    <= 1'b0;
      collision_signal <= 1'b0;
      pause_signal     <= 1'b0;
    end else begin
      if (btn_rise)         button_signal <= 1'b1;
      else if (ack_rise[0]) button_signal <= 1'b0;

      if (vs_rise)          screen_signal <= 1'b1;
      else if (ack_rise[1]) screen_signal <= 1'b0;

      if (check_pending && coll_hit) collision_signal <= 1'b1;
      else if (ack_rise[2])          collision_signal <= 1'b0;

      if (pause_rise) pause_signal <= ~pause_signal;
    end
  end
endmodule

// File: tb/tb_game_io_bridge.sv
// Bench for game_io_bridge with a short debounce: directed sequences, a collision vector
// table and randomized frames/bounces checked against a rule-level model.

module tb_game_io_bridge;
  localparam int DEB = 4;
  localparam longint DX = 40, DW = 20, DH = 24, OW = 12, OH = 20, GY = 200;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        btn_raw = 1'b0;
  logic        pause_raw = 1'b0;
  logic        vsync_raw = 1'b0;
  logic [31:0] dino_y_in = 32'd0;
  logic [31:0] obst_x_in = 32'd0;
  logic [31:0] ack_word = 32'd0;
  logic        button_signal, screen_signal, collision_signal, pause_signal;
  logic [31:0] dino_y_disp, obst_x_disp;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] dino_y;
    logic [31:0] obst_x;
    logic        exp_coll;
  } vec_t;

  vec_t vecs[10];
  logic [64:0] exp_q[$];

  game_io_bridge #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clock            (clock),
    .reset            (reset),
    .btn_raw          (btn_raw),
    .pause_raw        (pause_raw),
    .vsync_raw        (vsync_raw),
    .dino_y_in        (dino_y_in),
    .obst_x_in        (obst_x_in),
    .ack_word         (ack_word),
    .button_signal    (button_signal),
    .screen_signal    (screen_signal),
    .collision_signal (collision_signal),
    .pause_signal     (pause_signal),
    .dino_y_disp      (dino_y_disp),
    .obst_x_disp      (obst_x_disp)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic ack(input int bit_n);
    ack_word = 32'd1 << bit_n;
    step(2);
    ack_word = 32'd0;
    step(1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_button"}, {31'd0, button_signal}, 32'd0);
    check({tag, "_screen"}, {31'd0, screen_signal}, 32'd0);
    check({tag, "_collision"}, {31'd0, collision_signal}, 32'd0);
    check({tag, "_pause"}, {31'd0, pause_signal}, 32'd0);
    check({tag, "_dino_disp"}, dino_y_disp, 32'd0);
    check({tag, "_obst_disp"}, obst_x_disp, 32'd0);
  endtask

  // Reference collision rule evaluated with wide plain arithmetic.
  function automatic logic model_coll(input logic [31:0] y, input logic [31:0] x);
    longint unsigned yl, xl;
    yl = longint'(y);
    xl = longint'(x);
    return (xl < DX + DW) && (xl + OW > DX) && (yl + DH > GY - OH);
  endfunction

  // ---------------- stimulus + scoreboard ----------------
  initial begin
    vecs[0] = '{32'd170, 32'd50, 1'b1};
    vecs[1] = '{32'd156, 32'd50, 1'b0};
    vecs[2] = '{32'd157, 32'd50, 1'b1};
    vecs[3] = '{32'd170, 32'd60, 1'b0};
    vecs[4] = '{32'd170, 32'd59, 1'b1};
    vecs[5] = '{32'd170, 32'd28, 1'b0};
    vecs[6] = '{32'd170, 32'd29, 1'b1};
    vecs[7] = '{32'd100, 32'd300, 1'b0};
    vecs[8] = '{32'hFFFF_FFFF, 32'd50, 1'b1};
    vecs[9] = '{32'd170, 32'hFFFF_FFF8, 1'b0};

    // reset state
    step(2);
    check_all_zero("reset");
    reset = 1'b0;
    step(2);

    // button accept, acknowledge, re-press
    btn_raw = 1'b1;
    step(6);
    check("btn_early", {31'd0, button_signal}, 32'd0);
    step(1);
    check("btn_edge7", {31'd0, button_signal}, 32'd1);
    ack_word = 32'd1;
    step(1);
    check("btn_ack_edge1", {31'd0, button_signal}, 32'd1);
    step(1);
    check("btn_ack_edge2", {31'd0, button_signal}, 32'd0);
    ack_word = 32'd0;
    btn_raw = 1'b0;
    step(8);
    check("btn_release_no_set", {31'd0, button_signal}, 32'd0);
    btn_raw = 1'b1;
    step(7);
    check("btn_repress", {31'd0, button_signal}, 32'd1);
    ack(0);
    btn_raw = 1'b0;
    step(8);

    // bounce rejection: widths of 2 synchronized cycles
    for (int i = 0; i < 4; i++) begin
      btn_raw = (i % 2 == 0);
      step(2);
    end
    step(10);
    check("bounce_rejected", {31'd0, button_signal}, 32'd0);
    btn_raw = 1'b1;
    step(7);
    check("bounce_then_hold", {31'd0, button_signal}, 32'd1);
    ack(0);
    btn_raw = 1'b0;
    step(8);

    // snapshot and hold
    dino_y_in = 32'd100;
    obst_x_in = 32'd300;
    vsync_raw = 1'b1;
    step(2);
    check("screen_edge2", {31'd0, screen_signal}, 32'd0);
    step(1);
    check("screen_edge3", {31'd0, screen_signal}, 32'd1);
    check("snap_dino", dino_y_disp, 32'd100);
    check("snap_obst", obst_x_disp, 32'd300);
    dino_y_in = 32'd50;
    step(5);
    check("snap_hold", dino_y_disp, 32'd100);
    ack(1);
    check("screen_ack", {31'd0, screen_signal}, 32'd0);
    vsync_raw = 1'b0;
    step(3);
    vsync_raw = 1'b1;
    step(3);
    check("snap_next_frame", dino_y_disp, 32'd50);
    vsync_raw = 1'b0;
    step(3);

    // collision table
    foreach (vecs[i]) begin
      dino_y_in = vecs[i].dino_y;
      obst_x_in = vecs[i].obst_x;
      vsync_raw = 1'b1;
      step(3);
      check($sformatf("vec%0d_coll_edge3", i), {31'd0, collision_signal}, 32'd0);
      step(1);
      check($sformatf("vec%0d_coll_edge4", i), {31'd0, collision_signal}, {31'd0, vecs[i].exp_coll});
      vsync_raw = 1'b0;
      step(3);
      ack(2);
    end

    // set/clear race then held acknowledge
    dino_y_in = 32'd170;
    obst_x_in = 32'd50;
    vsync_raw = 1'b1;
    step(2);
    ack_word = 32'd4;
    step(2);
    check("race_set_wins", {31'd0, collision_signal}, 32'd1);
    vsync_raw = 1'b0;
    step(3);
    vsync_raw = 1'b1;
    step(4);
    check("held_ack_no_clear", {31'd0, collision_signal}, 32'd1);
    ack_word = 32'd0;
    step(1);
    ack(2);
    check("reack_clears", {31'd0, collision_signal}, 32'd0);
    vsync_raw = 1'b0;
    step(3);

    // pause toggle
    pause_raw = 1'b1;
    step(6);
    check("pause_early", {31'd0, pause_signal}, 32'd0);
    step(1);
    check("pause_first", {31'd0, pause_signal}, 32'd1);
    pause_raw = 1'b0;
    step(8);
    pause_raw = 1'b1;
    step(7);
    check("pause_second", {31'd0, pause_signal}, 32'd0);
    pause_raw = 1'b0;
    step(8);

    // asynchronous reset mid-count with some outputs high
    pause_raw = 1'b1;
    step(7);
    pause_raw = 1'b0;
    vsync_raw = 1'b1;
    step(3);
    vsync_raw = 1'b0;
    check("pre_reset_pause", {31'd0, pause_signal}, 32'd1);
    check("pre_reset_screen", {31'd0, screen_signal}, 32'd1);
    btn_raw = 1'b1;
    step(4);
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    step(2);
    reset = 1'b0;
    step(6);
    check("post_reset_early", {31'd0, button_signal}, 32'd0);
    step(1);
    check("post_reset_fresh", {31'd0, button_signal}, 32'd1);
    ack(0);
    btn_raw = 1'b0;
    step(8);

    // random pulse widths: accepted only when held DEB synchronized cycles
    for (int i = 0; i < 12; i++) begin
      int w;
      w = $urandom_range(1, 6);
      btn_raw = 1'b1;
      step(w);
      btn_raw = 1'b0;
      step(8);
      check($sformatf("rand_pulse%0d_w%0d", i, w), {31'd0, button_signal}, {31'd0, w >= DEB});
      ack(0);
    end

    // random frames through the scoreboard
    for (int i = 0; i < 40; i++) begin
      logic [64:0] e;
      logic [31:0] y, x;
      y = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(140, 220));
      x = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 100));
      dino_y_in = y;
      obst_x_in = x;
      exp_q.push_back({model_coll(y, x), y, x});
      vsync_raw = 1'b1;
      step(4);
      e = exp_q.pop_front();
      check($sformatf("rand%0d_dino", i), dino_y_disp, e[63:32]);
      check($sformatf("rand%0d_obst", i), obst_x_disp, e[31:0]);
      check($sformatf("rand%0d_coll", i), {31'd0, collision_signal}, {31'd0, e[64]});
      dino_y_in = $urandom;
      obst_x_in = $urandom;
      step(2);
      check($sformatf("rand%0d_hold", i), dino_y_disp, e[63:32]);
      vsync_raw = 1'b0;
      step(3);
      ack(2);
    end

    // ---------------- report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
